// File: rtl/program_loader_if.sv
// Byte-stream, instruction-memory and status signals of the UART program loader.
interface program_loader_if #(
  parameter int ADDR_W = 14
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;
  logic              ack_valid;
  logic [7:0]        ack_data;

  modport master (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata, core_rst, done, err, ack_valid, ack_data
  );

  modport slave (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata, core_rst, done, err, ack_valid, ack_data
  );
endinterface

// File: rtl/program_loader.sv
// UART bootloader: little-endian word count N, then N words written to imem[0..N-1].
// Define LOADER_CHECKSUM_EN to require a trailing XOR-of-payload word before DONE.
module program_loader #(
  parameter int ADDR_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);
  localparam logic [7:0]        ACK_OK    = 8'hAA;
  localparam logic [7:0]        ACK_ERR   = 8'h55;
  localparam logic [32:0]       MAX_WORDS = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t            r_state;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_word;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst;
  logic              r_done;
  logic              r_err;
  logic              r_ack_v;
  logic [7:0]        r_ack_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       r_csum;
`endif

  logic [31:0]       w_word;
  logic              w_rx_st;
  logic              w_word_done;
  logic              w_fits;
  logic [ADDR_W:0]   w_idx_nxt;

  // Bytes arrive LSB first, so each new byte lands on top of the three held ones.
  assign w_word      = {bus.rx_data, r_word};
`ifdef LOADER_CHECKSUM_EN
  assign w_rx_st     = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CSUM);
`else
  assign w_rx_st     = (r_state == S_HDR) || (r_state == S_LOAD);
`endif
  assign w_word_done = bus.rx_valid && w_rx_st && (r_bcnt == 2'd3);
  assign w_fits      = {1'b0, w_word} <= MAX_WORDS;
  // Index is one bit wider than the address so a full-capacity load never wraps.
  assign w_idx_nxt   = r_idx + IDX_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HDR;
      r_bcnt     <= '0;
      r_word     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ack_v    <= 1'b0;
      r_ack_d    <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_we    <= 1'b0;
      r_ack_v <= 1'b0;
      if (bus.rx_valid && w_rx_st) begin
        r_bcnt <= r_bcnt + 2'd1;
        r_word <= w_word[31:8];
      end
      case (r_state)
        S_HDR: if (w_word_done) begin
          if (w_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ack_v <= 1'b1;
            r_ack_d <= ACK_OK;
`endif
          end else if (!w_fits) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_ack_v <= 1'b1;
            r_ack_d <= ACK_ERR;
          end else begin
            r_n     <= w_word[ADDR_W:0];
            r_idx   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: if (w_word_done) begin
          r_we    <= 1'b1;
          r_addr  <= r_idx[ADDR_W-1:0];
          r_wdata <= w_word;
          r_idx   <= w_idx_nxt;
`ifdef LOADER_CHECKSUM_EN
          r_csum  <= r_csum ^ w_word;
          if (w_idx_nxt == r_n) r_state <= S_CSUM;
`else
          if (w_idx_nxt == r_n) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ack_v <= 1'b1;
            r_ack_d <= ACK_OK;
          end
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (w_word_done) begin
          r_ack_v <= 1'b1;
          if (w_word == r_csum) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ack_d <= ACK_OK;
          end else begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_ack_d <= ACK_ERR;
          end
        end
`endif
        // done has been high for a cycle here, so the final write has already landed.
        S_DONE:  r_core_rst <= 1'b0;
        S_ERR:   ;
        default: r_state <= S_HDR;
      endcase
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_rst   = r_core_rst;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.ack_valid  = r_ack_v;
  assign bus.ack_data   = r_ack_d;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random byte streams checked against a stream-level model.
module tb_program_loader;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  program_loader_if #(.ADDR_W(AW)) bus ();
  program_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Observed activity, sampled on the falling edge.
  logic [AW+31:0] wq[$];
  logic [7:0]     aq[$];
  int   cyc = 0, done_rise = -1, crst_fall = -1, both_cnt = 0;
  logic p_done = 1'b0, p_crst = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (bus.imem_we)   wq.push_back({bus.imem_addr, bus.imem_wdata});
    if (bus.ack_valid) aq.push_back(bus.ack_data);
    if (bus.done && !p_done)     done_rise = cyc;
    if (!bus.core_rst && p_crst) crst_fall = cyc;
    if (bus.done && bus.err)     both_cnt++;
    p_done = bus.done;
    p_crst = bus.core_rst;
  end

  // Reference: parse the stream by its byte layout.
  logic [AW+31:0] exp_w[$];
  int             exp_status;  // 0 incomplete, 1 done, 2 error

  function automatic logic [31:0] word_at(bytes_t s, int i);
    return {s[i+3], s[i+2], s[i+1], s[i]};
  endfunction

  function automatic bytes_t add_word(bytes_t s, logic [31:0] w);
    bytes_t r = s;
    for (int b = 0; b < 4; b++) r.push_back(w[8*b +: 8]);
    return r;
  endfunction

  function automatic bytes_t with_trailer(bytes_t s);
    bytes_t r = s;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] x = '0;
    longint n = word_at(s, 0);
    for (int k = 0; k < n; k++) x ^= word_at(s, 4 + 4*k);
    r = add_word(r, x);
`endif
    return r;
  endfunction

  task automatic model(input bytes_t s);
    longint n;
    logic [31:0] x = '0;
    exp_w.delete();
    exp_status = 0;
    if (s.size() < 4) return;
    n = word_at(s, 0);
    if (n > CAP) begin exp_status = 2; return; end
    if (s.size() < 4 + 4*n) return;
    for (int k = 0; k < n; k++) begin
      logic [31:0] w = word_at(s, 4 + 4*k);
      exp_w.push_back({AW'(k), w});
      x ^= w;
    end
`ifdef LOADER_CHECKSUM_EN
    if (s.size() < 8 + 4*n) return;
    exp_status = (word_at(s, 4 + 4*n) == x) ? 1 : 2;
`else
    exp_status = 1;
`endif
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g = $urandom_range(maxgap, 0);
    repeat (g) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      tick();
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_load(input string name, input bytes_t s, input bit do_rst);
    int wb, ab, nexp_ack;
    logic [AW+31:0] last;
    logic [7:0] eack;
    if (do_rst) do_reset();
    wb = wq.size();
    ab = aq.size();
    model(s);
    foreach (s[i]) send_byte(s[i], 2);
    repeat (6) tick();

    nvec++;
    if (wq.size() - wb != exp_w.size()) begin
      nmis++;
      $display("FAIL %s write count: got %0d want %0d", name, wq.size() - wb, exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        nvec++;
        if (wq[wb+i] !== exp_w[i]) begin
          nmis++;
          $display("FAIL %s write[%0d] {addr,data}: got %h want %h", name, i, wq[wb+i], exp_w[i]);
        end
      end
    end

    nexp_ack = (exp_status != 0) ? 1 : 0;
    eack     = (exp_status == 1) ? 8'hAA : 8'h55;
    nvec++;
    if (aq.size() - ab != nexp_ack) begin
      nmis++;
      $display("FAIL %s ack count: got %0d want %0d", name, aq.size() - ab, nexp_ack);
    end else if (nexp_ack == 1) begin
      nvec++;
      if (aq[ab] !== eack) begin
        nmis++;
        $display("FAIL %s ack byte: got %h want %h", name, aq[ab], eack);
      end
    end

    nvec++;
    if ({bus.done, bus.err, bus.core_rst} !== {exp_status == 1, exp_status == 2, exp_status != 1}) begin
      nmis++;
      $display("FAIL %s {done,err,core_rst}: got %b%b%b want %b%b%b", name, bus.done, bus.err,
               bus.core_rst, exp_status == 1, exp_status == 2, exp_status != 1);
    end

    if (exp_status == 1) begin
      nvec++;
      if (crst_fall - done_rise != 1) begin
        nmis++;
        $display("FAIL %s core_rst release lag: got %0d want 1 cycle", name, crst_fall - done_rise);
      end
    end

    last = (exp_w.size() > 0) ? exp_w[exp_w.size()-1] : '0;
    nvec++;
    if ({bus.imem_addr, bus.imem_wdata} !== last) begin
      nmis++;
      $display("FAIL %s final {addr,data}: got %h want %h", name, {bus.imem_addr, bus.imem_wdata}, last);
    end

    nvec++;
    if (both_cnt != 0) begin
      nmis++;
      $display("FAIL %s done&err both high: got %0d cycles want 0", name, both_cnt);
    end
  endtask

  function automatic bytes_t example_stream();
    bytes_t s = '{8'h02, 8'h00, 8'h00, 8'h00,
                  8'h13, 8'h05, 8'h10, 8'h00,
                  8'h93, 8'h05, 8'h20, 8'h00};
    return with_trailer(s);
  endfunction

  task automatic test_example();
    run_load("example", example_stream(), 1'b1);
    nvec++;
    if (exp_w.size() != 2 || exp_w[0] !== {4'd0, 32'h00100513} || exp_w[1] !== {4'd1, 32'h00200593}) begin
      nmis++;
      $display("FAIL example model words: got %0d entries want 2 fixed words", exp_w.size());
    end
  endtask

  task automatic test_reset();
    logic [AW+44:0] got, want;
    run_load("pre_reset", example_stream(), 1'b1);
    rst = 1'b0;
    #1;
    got  = {bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_rst, bus.done, bus.err,
            bus.ack_valid, bus.ack_data};
    want = {1'b0, {AW{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL reset outputs: got %h want %h", got, want);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    bytes_t s = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load("zero_words", with_trailer(s), 1'b1);
  endtask

  task automatic test_overflow();
    bytes_t s = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    bytes_t h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("n_17", s, 1'b1);
    run_load("n_huge", h, 1'b1);
  endtask

  task automatic test_max();
    bytes_t s = '{};
    s = add_word(s, CAP);
    for (int k = 0; k < CAP; k++) s = add_word(s, $urandom);
    run_load("n_cap", with_trailer(s), 1'b1);
  endtask

  task automatic test_mid_reset();
    bytes_t part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10};
    bytes_t s    = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    foreach (part[i]) send_byte(part[i], 1);
    run_load("mid_reset", with_trailer(s), 1'b1);
  endtask

  task automatic test_extra_bytes();
    bytes_t s = example_stream();
    for (int i = 0; i < 9; i++) s.push_back(8'($urandom));
    run_load("extra_bytes", s, 1'b1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bytes_t s = '{};
    bytes_t g, b;
    s = add_word(s, 32'd2);
    s = add_word(s, 32'h11111111);
    s = add_word(s, 32'h22222222);
    g = add_word(s, 32'h33333333);
    b = add_word(s, 32'h33333334);
    run_load("csum_good", g, 1'b1);
    run_load("csum_bad", b, 1'b1);
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      bytes_t s = '{};
      int n = (it % 7 == 6) ? int'($urandom_range(1000, CAP + 1)) : int'($urandom_range(CAP + 2, 0));
      s = add_word(s, n);
      if (n <= CAP) for (int k = 0; k < n; k++) s = add_word(s, $urandom);
      s = with_trailer(s);
`ifdef LOADER_CHECKSUM_EN
      if (n <= CAP && $urandom_range(3, 0) == 0) s[s.size()-1] = s[s.size()-1] ^ 8'h01;
`endif
      for (int e = $urandom_range(3, 0); e > 0; e--) s.push_back(8'($urandom));
      run_load($sformatf("random_%0d", it), s, 1'b1);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick();
    test_reset();
    test_example();
    test_zero();
    test_overflow();
    test_max();
    test_mid_reset();
    test_extra_bytes();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 14, instruction memory word-address width (capacity 2^ADDR_W words).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-007 imem_addr  output  ADDR_W  instruction memory word address.
REQ-008 imem_wdata  output  32  instruction word to write.
REQ-009 core_rst  output  1  active-high reset to the single-cycle core; held 1 until load completes.
REQ-010 done  output  1  load completed successfully; level.
REQ-011 err  output  1  load aborted; level.
REQ-012 ack_valid  output  1  one-cycle strobe to UART transmitter.
REQ-013 ack_data  output  8  status byte sent with ack_valid.

Function
REQ-014 Byte stream SHALL be little-endian: 4-byte header word count N, then 4N payload bytes; payload word k goes to imem_addr k.
REQ-015 FSM states SHALL be HDR, LOAD, (CSUM when configured), DONE, ERR; reset state HDR.
REQ-016 A 2-bit byte counter SHALL assemble bytes into a 32-bit word; bytes arriving without rx_valid SHALL be ignored.
REQ-017 HDR: after 4th header byte, N=0 -> DONE; N > 2^ADDR_W -> ERR; otherwise -> LOAD with word index 0.
REQ-018 LOAD: rx_valid on 4th byte of word k in cycle T -> imem_we=1, imem_addr=k, imem_wdata=word in cycle T+1; word index increments.
REQ-019 After word N-1 is accepted, state SHALL go to DONE (or CSUM if configured) on the same edge that registers its write.
REQ-020 done SHALL assert on entry to DONE; core_rst SHALL deassert one cycle after done asserts, so the last write lands before the core's first fetch.
REQ-021 Entering DONE SHALL pulse ack_valid once with ack_data=0xAA; entering ERR SHALL pulse ack_valid once with ack_data=0x55.
REQ-022 DONE and ERR SHALL be terminal: rx bytes ignored, no imem_we, until rst asserted.
REQ-023 In ERR core_rst SHALL remain 1 and err=1; done and err SHALL never both be 1.
REQ-024 N = 2^ADDR_W SHALL be legal; word index SHALL not wrap during a legal load.
REQ-025 imem_we SHALL never assert outside LOAD-originated writes.

Reset
REQ-026 rst low SHALL immediately force: state HDR, counters 0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0, ack_valid=0, ack_data=0.
REQ-027 rst asserted mid-load SHALL abandon the partial load; a new load restarts from the header after release.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: after payload, a 4-byte trailer (XOR of all payload words) is received in CSUM; match -> DONE, mismatch -> ERR; N=0 expects trailer 0x00000000.
REQ-029 Macro LOADER_CHECKSUM_EN undefined: no CSUM state, no trailer; LOAD goes directly to DONE.

Verification
REQ-030 Header 02 00 00 00, payload 13 05 10 00 | 93 05 20 00 -> writes addr0=0x00100513, addr1=0x00200593; done=1; ack 0xAA; core_rst low one cycle after done.
REQ-031 Header 00 00 00 00 (no checksum build) -> no imem_we, DONE, ack 0xAA.
REQ-032 ADDR_W=4, header 11 00 00 00 (N=17) -> ERR, err=1, ack 0x55, core_rst stays 1, no writes.
REQ-033 rst pulsed after 3 payload bytes of a 2-word load, then full 1-word load of 0xDEADBEEF -> single write addr0=0xDEADBEEF, done=1.
REQ-034 LOADER_CHECKSUM_EN, 2-word payload 0x11111111, 0x22222222, trailer 0x33333333 -> DONE; trailer 0x33333334 -> ERR, ack 0x55.
REQ-035 Extra bytes after DONE -> no imem_we, no further ack, outputs unchanged.
